nibble_serial_alu: RTL and testbench

- Sequential 8-bit arithmetic/logic unit for the 6502 datapath.
- Built from a single 4-bit ALU slice: each 8-bit operation is processed low nibble first, then high nibble, across two cycles.
- Latches the inter-nibble carry, applies BCD decimal adjust, and produces the 6502 N/Z/C/V flags.
- Sits between the instruction sequencer (producer, valid/ready) and the register/flag write-back stage (consumer, valid/ready).

---
 rtl/nibble_serial_alu.sv | 193 +++++++++++++++++++
 tb/tb_nibble_serial_alu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_alu.sv
// 8-bit 6502 ALU built on one 4-bit slice: low nibble in LO, high nibble in HI.
// Handles the inter-nibble carry, BCD adjust for ADC/SBC and the N/Z/C/V flags.
module nibble_serial_alu (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    input  logic       d_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic       n_out,
    output logic       z_out,
    output logic       c_out,
    output logic       v_out
);

    localparam logic [2:0] OP_ADC = 3'd0;
    localparam logic [2:0] OP_SBC = 3'd1;
    localparam logic [2:0] OP_ORA = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // One nibble of the slice: returns {carry_out, nibble}, BCD-adjusted when f_dec is set.
    function automatic logic [4:0] nibble_slice(
        input logic [2:0] f_op,
        input logic       f_dec,
        input logic [3:0] f_a,
        input logic [3:0] f_b,
        input logic       f_cin
    );
        logic [3:0] b_eff;
        logic [4:0] sum;
        logic [4:0] res;
        b_eff = (f_op == OP_SBC) ? ~f_b : f_b;
        sum   = {1'b0, f_a} + {1'b0, b_eff} + {4'd0, f_cin};
        res   = sum;
        case (f_op)
            OP_ADC: begin
                if (f_dec && (sum > 5'd9)) begin
                    res = {1'b1, sum[3:0] + 4'd6};
                end
            end
            OP_SBC: begin
                if (f_dec && !sum[4]) begin
                    res = {1'b0, sum[3:0] - 4'd6};
                end
            end
            OP_ORA:  res = {1'b0, f_a | f_b};
            OP_EOR:  res = {1'b0, f_a ^ f_b};
            default: res = {1'b0, f_a & f_b};
        endcase
        return res;
    endfunction

    function automatic logic signed_overflow(
        input logic [7:0] f_a,
        input logic [7:0] f_b,
        input logic       f_cin
    );
        logic signed [9:0] total;
        total = $signed({{2{f_a[7]}}, f_a}) + $signed({{2{f_b[7]}}, f_b})
              + $signed({9'd0, f_cin});
        return (total > 10'sd127) || (total < -10'sd128);
    endfunction

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic       dec_q, dec_d;
    logic [3:0] lo_nib_q, lo_nib_d;
    logic       hc_q, hc_d;
    logic [7:0] result_q, result_d;
    logic       n_q, n_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       v_q, v_d;

    logic [4:0] lo_slice;
    logic [4:0] hi_slice;
    logic [7:0] b_eff;
    logic [7:0] full_result;
    logic       is_arith;

    assign lo_slice    = nibble_slice(op_q, dec_q, a_q[3:0], b_q[3:0], cin_q);
    assign hi_slice    = nibble_slice(op_q, dec_q, a_q[7:4], b_q[7:4], hc_q);
    assign b_eff       = (op_q == OP_SBC) ? ~b_q : b_q;
    assign is_arith    = (op_q == OP_ADC) || (op_q == OP_SBC);
    assign full_result = {hi_slice[3:0], lo_nib_q};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        dec_d     = dec_q;
        lo_nib_d  = lo_nib_q;
        hc_d      = hc_q;
        result_d  = result_q;
        n_d       = n_q;
        z_d       = z_q;
        c_d       = c_q;
        v_d       = v_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cin_d   = c_in;
                    dec_d   = d_in;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                lo_nib_d = lo_slice[3:0];
                hc_d     = lo_slice[4];
                state_d  = ST_HI;
            end
            ST_HI: begin
                result_d = full_result;
                n_d      = full_result[7];
                z_d      = (full_result == 8'h00);
                c_d      = is_arith ? hi_slice[4] : cin_q;
                // Overflow follows the plain binary sum even in decimal mode.
                v_d      = is_arith ? signed_overflow(a_q, b_eff, cin_q) : 1'b0;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            cin_q    <= 1'b0;
            dec_q    <= 1'b0;
            lo_nib_q <= 4'h0;
            hc_q     <= 1'b0;
            result_q <= 8'h00;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            dec_q    <= dec_d;
            lo_nib_q <= lo_nib_d;
            hc_q     <= hc_d;
            result_q <= result_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    assign result = result_q;
    assign n_out  = n_q;
    assign z_out  = z_q;
    assign c_out  = c_q;
    assign v_out  = v_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Bench for nibble_serial_alu: directed vector table, random ops against a
// behavioural model, and hand-written backpressure / mid-operation reset sequences.
module tb_nibble_serial_alu;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       d_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       n_out;
    logic       z_out;
    logic       c_out;
    logic       v_out;

    int checks = 0;
    int errors = 0;

    nibble_serial_alu dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .d_in     (d_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .n_out    (n_out),
        .z_out    (z_out),
        .c_out    (c_out),
        .v_out    (v_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       d;
        logic [7:0] r;
        logic       n;
        logic       z;
        logic       cf;
        logic       v;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {result, N, Z, C, V} from whole-byte arithmetic, nibble BCD rules for decimal.
    function automatic logic [11:0] model(input logic [2:0] mop, input logic [7:0] ma,
                                          input logic [7:0] mb, input logic mc, input logic md);
        int ai, bi, sa, sb, sum, lo, hi, cl, ch, r;
        logic cout, v;
        logic [7:0] rb;
        ai   = int'(ma);
        bi   = int'(mb);
        r    = 0;
        cout = mc;
        v    = 1'b0;
        if (mop == 3'd0 || mop == 3'd1) begin
            if (mop == 3'd1) bi = 255 - bi;
            sa  = (ai > 127) ? ai - 256 : ai;
            sb  = (bi > 127) ? bi - 256 : bi;
            sum = sa + sb + int'(mc);
            v   = (sum > 127) || (sum < -128);
            if (!md) begin
                sum  = ai + bi + int'(mc);
                r    = sum % 256;
                cout = (sum > 255);
            end else begin
                lo = (ai % 16) + (bi % 16) + int'(mc);
                if (mop == 3'd0) begin
                    cl = (lo > 9) ? 1 : 0;
                    if (lo > 9) lo = lo + 6;
                end else begin
                    cl = (lo > 15) ? 1 : 0;
                    if (cl == 0) lo = lo - 6;
                end
                hi = (ai / 16) + (bi / 16) + cl;
                if (mop == 3'd0) begin
                    ch = (hi > 9) ? 1 : 0;
                    if (hi > 9) hi = hi + 6;
                end else begin
                    ch = (hi > 15) ? 1 : 0;
                    if (ch == 0) hi = hi - 6;
                end
                r    = ((hi & 15) * 16) + (lo & 15);
                cout = (ch != 0);
            end
        end else begin
            case (mop)
                3'd3:    r = ai | bi;
                3'd4:    r = ai ^ bi;
                default: r = ai & bi;
            endcase
        end
        rb = r[7:0];
        return {rb, rb[7], (rb == 8'h00), cout, v};
    endfunction

    task automatic run_op(input logic [2:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                          input logic t_c, input logic t_d,
                          output logic [11:0] got, output int lat);
        op       = t_op;
        a        = t_a;
        b        = t_b;
        c_in     = t_c;
        d_in     = t_d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
        c_in     = 1'($urandom);
        d_in     = 1'($urandom);
        lat      = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {result, n_out, z_out, c_out, v_out};
        @(posedge clk); #1;
    endtask

    initial begin
        logic [11:0] got;
        logic [11:0] exp;
        logic [11:0] held;
        int          lat;
        logic [2:0]  r_op;
        logic [7:0]  r_a, r_b;
        logic        r_c, r_d;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'd0;
        a         = 8'h00;
        b         = 8'h00;
        c_in      = 1'b0;
        d_in      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result_flags", {result, n_out, z_out, c_out, v_out}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        vecs[0]  = '{3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{3'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'd0, 8'h19, 8'h28, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{3'd1, 8'h42, 8'h13, 1'b1, 1'b1, 8'h29, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{3'd4, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{3'd3, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd2, 8'hAA, 8'h0F, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd5, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{3'd1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{3'd0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'd1, 8'h00, 8'h01, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, got, lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_result", i), got[11:4], vecs[i].r);
            check($sformatf("vec%0d_nzcv", i), got[3:0],
                  {vecs[i].n, vecs[i].z, vecs[i].cf, vecs[i].v});
        end

        for (int i = 0; i < 150; i++) begin
            r_op = 3'($urandom);
            r_a  = 8'($urandom);
            r_b  = 8'($urandom);
            r_c  = 1'($urandom);
            r_d  = 1'($urandom);
            exp  = model(r_op, r_a, r_b, r_c, r_d);
            run_op(r_op, r_a, r_b, r_c, r_d, got, lat);
            check($sformatf("rand%0d_latency", i), lat, 3);
            check($sformatf("rand%0d_op%0d_a%0h_b%0h_c%0d_d%0d", i, r_op, r_a, r_b, r_c, r_d),
                  got, exp);
        end

        // Backpressure: result held, request during DONE dropped.
        out_ready = 1'b0;
        op        = 3'd0;
        a         = 8'h50;
        b         = 8'h50;
        c_in      = 1'b0;
        d_in      = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, 3);
        held = {result, n_out, z_out, c_out, v_out};
        check("bp_result", held, {8'hA0, 4'b1001});
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = 3'd4;
            a        = 8'h3C;
            b        = 8'hC3;
            c_in     = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp%0d_out_valid", i), out_valid, 1);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
            check($sformatf("bp%0d_stable", i), {result, n_out, z_out, c_out, v_out}, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_no_queue%0d", i), out_valid, 0);
        end

        // Reset while the high nibble is being computed.
        op       = 3'd0;
        a        = 8'h12;
        b        = 8'h34;
        c_in     = 1'b1;
        d_in     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_lo_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_hi_out_valid", out_valid, 0);
        check("rst_hi_in_ready", in_ready, 1);
        check("rst_hi_result_flags", {result, n_out, z_out, c_out, v_out}, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("rst_no_partial%0d", i), out_valid, 0);
        end
        check("rst_recover", {result, n_out, z_out, c_out, v_out}, 0);
        run_op(3'd0, 8'h12, 8'h34, 1'b1, 1'b0, got, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_result", got, {8'h47, 4'b0000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog timeout");
    end

endmodule
